// File: rtl/div_seq_if.sv
// div_seq_if: request/result bundle for the sequential divider.
// Request (master drives): start, dividend, divisor.
// Result (slave drives): busy, done, quotient, remainder, div_by_zero.
interface div_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: unsigned restoring divider, one quotient bit per clock.
// Latency: done pulses after edge T0+WIDTH+1 (T0+1 for a zero divisor).
// Backpressure: none; start is only sampled in IDLE, never queued.
// Ports: clk (rising edge), rst (async, active high), bus (div_seq_if.slave).
module div_seq #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  div_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;      // shifting quotient, dividend bits fed out of the top
  logic [WIDTH-1:0] r_rem;    // partial remainder, always < divisor
  logic [WIDTH-1:0] r_dvs;    // divisor captured at start
  logic [CW-1:0]    r_cnt;    // quotient bits still to produce
  logic             r_dz;     // zero-divisor operation in flight
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic             r_dzo;

  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_diff;
  logic             w_take;

  // Shifted partial remainder needs WIDTH+1 bits: 2*R+1 can exceed 2^WIDTH-1.
  assign w_rsh  = {r_rem, r_q[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_dvs};
  // Since R < D, w_rsh < 2*D, so a non-negative difference is < D < 2^WIDTH and
  // a negative one wraps to >= 2^WIDTH: bit WIDTH alone is the borrow.
  assign w_take = ~w_diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dzo   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_q    <= bus.dividend;
            r_dvs  <= bus.divisor;
            r_rem  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_busy <= 1'b1;
            if (bus.divisor == '0) begin
              r_dz    <= 1'b1;
              r_state <= FIN;
            end else begin
              r_dz    <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          // Restoring step: keep the shifted remainder when the trial underflows.
          r_rem <= w_take ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_take};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (r_dz) begin
            r_quo <= '1;
            r_rmd <= r_q;   // r_q still holds the untouched dividend
            r_dzo <= 1'b1;
          end else begin
            r_quo <= r_q;
            r_rmd <= r_rem;
            r_dzo <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rmd;
  assign bus.div_by_zero = r_dzo;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed-vector bench for div_seq (WIDTH=4).
// Table of {dividend, divisor, quotient, remainder, div_by_zero} plus
// hand-written sequences for reset, start-while-busy and a held-start sweep.
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  div_seq_if #(.WIDTH(4)) bus ();

  div_seq #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One operation with a single-cycle start; operands are scrambled after T0.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output int lat, output int bsy,
                        output logic extra, output logic hold_ok);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = ~a; bus.divisor = ~b;
    lat = 0; bsy = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bsy++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
    @(negedge clk);
    extra   = bus.done;
    hold_ok = (bus.quotient == q) && (bus.remainder == r) && (bus.div_by_zero == dz);
  endtask

  initial begin
    logic [3:0] q, r;
    logic       dz, extra, hold_ok;
    int         lat, bsy, cnt, n;

    n_vec = 0; n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    vecs[3] = '{4'd2,  4'd9,  4'd0,  4'd2, 1'b0};
    vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    vecs[5] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
    vecs[6] = '{4'd6,  4'd2,  4'd3,  4'd0, 1'b0};
    vecs[7] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0};

    // Reset pulse mid-cycle: outputs clear without waiting for a clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quo",  int'(bus.quotient), 0);
    chk("rst_rem",  int'(bus.remainder), 0);
    chk("rst_dz",   int'(bus.div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle with start low: nothing happens.
    cnt = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
      if (bus.busy) n++;
    end
    chk("idle_done", cnt, 0);
    chk("idle_busy", n, 0);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, dz, lat, bsy, extra, hold_ok);
      chk($sformatf("v%0d_quo", i), int'(q), int'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), int'(r), int'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), int'(dz), int'(vecs[i].dz));
      chk($sformatf("v%0d_lat", i), lat, vecs[i].dz ? 1 : 5);
      chk($sformatf("v%0d_busy", i), bsy, vecs[i].dz ? 1 : 5);
      chk($sformatf("v%0d_pulse", i), int'(extra), 0);
      chk($sformatf("v%0d_hold", i), int'(hold_ok), 1);
    end

    // Start pulsed during CALC is ignored and not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd13; bus.divisor = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd15; bus.divisor = 4'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0; q = '0; r = '0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) begin
        cnt++;
        q = bus.quotient;
        r = bus.remainder;
      end
      @(negedge clk);
    end
    chk("busy_start_dones", cnt, 1);
    chk("busy_start_quo", int'(q), 4);
    chk("busy_start_rem", int'(r), 1);

    // Reset during CALC of 14/4 discards the operation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_quo",  int'(bus.quotient), 0);
    chk("midrst_rem",  int'(bus.remainder), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    run_op(4'd14, 4'd4, q, r, dz, lat, bsy, extra, hold_ok);
    chk("after_rst_quo", int'(q), 3);
    chk("after_rst_rem", int'(r), 2);
    chk("after_rst_lat", lat, 5);

    // Exhaustive sweep with start held high; new operands presented in each done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.dividend = 4'(a);
        bus.divisor  = 4'(b);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.done && n < 20);
        q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
        if (b != 0) begin
          chk($sformatf("sw_%0d_%0d_inv", a, b), int'(q) * b + int'(r), a);
          chk($sformatf("sw_%0d_%0d_rlt", a, b), int'(int'(r) < b), 1);
          chk($sformatf("sw_%0d_%0d_dz", a, b), int'(dz), 0);
          chk($sformatf("sw_%0d_%0d_lat", a, b), n, 6);
        end else begin
          chk($sformatf("sw_%0d_0_quo", a), int'(q), 15);
          chk($sformatf("sw_%0d_0_rem", a), int'(r), a);
          chk($sformatf("sw_%0d_0_dz", a), int'(dz), 1);
          chk($sformatf("sw_%0d_0_lat", a), n, 2);
        end
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
